decode_stage: RTL

//  IF/ID pipeline register plus main/ALU decoder. It sits directly downstream of the fetch stage.
//  - Latches the fetched instruction and PC.
//  - Splits the instruction into fields.
//  - Drives branch/jump/ExtOp/imm16/target back to fetch and the control bundle forward to EX.
//  - Detects load-use hazards, emits a stall and inserts bubbles. Handles branch/jump flushes.

---
 rtl/decode_stage_pkg.sv | 49 ++++
 rtl/decode_stage_main_decoder.sv | 92 +++++++++
 rtl/decode_stage.sv | 96 +++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode constants, ALU encodings and the control bundle.
// Used by the ID stage and its main decoder.
package decode_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_LUI = 3'b101
  } alu_ctr_e;

  typedef struct packed {
    logic     reg_dst;
    logic     alu_src;
    logic     mem_to_reg;
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     jump;
    logic     ext_op;
    alu_ctr_e alu_ctr;
  } ctrl_t;

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/decode_stage_main_decoder.sv
// Combinational main/ALU decoder.
// Maps (op, funct) to the control bundle and an illegal flag.
module main_decoder
  import decode_stage_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       illegal
);

  logic r;
  assign r = (op == OP_RTYPE);

  // one-hot opcode/funct match into control bits
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      r && (funct == FN_ADDU): begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctr   = ALU_ADD;
      end
      r && (funct == FN_SUBU): begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctr   = ALU_SUB;
      end
      r && (funct == FN_AND): begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctr   = ALU_AND;
      end
      r && (funct == FN_OR): begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctr   = ALU_OR;
      end
      r && (funct == FN_SLT): begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctr   = ALU_SLT;
      end
      r && (funct == FN_SLL): begin
        ctrl = '0;
      end
      op == OP_ADDIU: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.ext_op    = 1'b1;
        ctrl.alu_ctr   = ALU_ADD;
      end
      op == OP_ORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctr   = ALU_OR;
      end
      op == OP_LUI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctr   = ALU_LUI;
      end
      op == OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.ext_op     = 1'b1;
        ctrl.alu_ctr    = ALU_ADD;
      end
      op == OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.ext_op    = 1'b1;
        ctrl.alu_ctr   = ALU_ADD;
      end
      op == OP_BEQ: begin
        ctrl.branch  = 1'b1;
        ctrl.ext_op  = 1'b1;
        ctrl.alu_ctr = ALU_SUB;
      end
      op == OP_J: begin
        ctrl.jump = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// IF/ID register, load-use hazard detection and bubble gating.
// Fields and controls are combinational from the latched word.
module decode_stage #(
  parameter logic [31:0] NOP_INST = decode_stage_pkg::NOP_INST,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  input  logic        flush,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  output logic        hazard_stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm16,
  output logic [25:0] target,
  output logic        branch,
  output logic        jump,
  output logic        ExtOp,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  ALUctr,
  output logic        illegal
);
  import decode_stage_pkg::*;

  logic [5:0] op;
  logic [5:0] funct;
  ctrl_t      dec_ctrl;
  ctrl_t      ctrl;
  logic       dec_illegal;
  logic       kill;

  assign op     = id_inst[31:26];
  assign funct  = id_inst[5:0];
  assign rs     = id_inst[25:21];
  assign rt     = id_inst[20:16];
  assign rd     = id_inst[15:11];
  assign shamt  = id_inst[10:6];
  assign imm16  = id_inst[15:0];
  assign target = id_inst[25:0];

  // IF/ID register: flush beats stall, stall holds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_inst  <= NOP_INST;
      id_pc    <= RESET_PC;
      id_valid <= 1'b0;
    end else if (flush) begin
      id_inst  <= NOP_INST;
      id_pc    <= RESET_PC;
      id_valid <= 1'b0;
    end else if (!hazard_stall) begin
      id_inst  <= if_inst;
      id_pc    <= if_pc;
      id_valid <= 1'b1;
    end
  end

  assign hazard_stall = id_valid && ex_mem_read && (ex_rt != 5'd0) &&
                        ((ex_rt == rs) || ((ex_rt == rt) && uses_rt(op)));

  main_decoder u_dec (
    .op      (op),
    .funct   (funct),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign kill    = hazard_stall || !id_valid;
  assign ctrl    = kill ? '0 : dec_ctrl;
  assign illegal = !kill && dec_illegal;

  assign RegDst   = ctrl.reg_dst;
  assign ALUSrc   = ctrl.alu_src;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign branch   = ctrl.branch;
  assign jump     = ctrl.jump;
  assign ExtOp    = ctrl.ext_op;
  assign ALUctr   = ctrl.alu_ctr;

endmodule
